user_io_input_conditioner: RTL

- Sits between the raw user I/O pins and the 8-bit bidirectional PIO's input side.
- Per bit, it synchronises each pin, debounces it and drives the clean value out on debounced; that bus feeds the PIO data-in path.
- Per bit, it captures programmable rising/falling edges into sticky flags and raises a maskable level interrupt.
- Register access is through an Avalon-MM slave: 2-bit word address, zero write wait states, read latency 1.

---
 rtl/user_io_input_conditioner.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/user_io_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : user_io_input_conditioner
// Description : Conditions raw user I/O pins for the PIO input side. Each bit
//               is synchronised, debounced and edge-detected. Programmable
//               rising/falling edges set sticky capture flags, which drive a
//               maskable level interrupt. The registers sit behind an
//               Avalon-MM slave (2-bit word address, read latency 1).
// Revision    : 1.0 - initial release
// ============================================================================
module user_io_input_conditioner #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [WIDTH-1:0]  pins_in,
   output logic [WIDTH-1:0]  debounced,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              irq
);

   // The fall-enable field lives in bits [31:16], so at most 16 bits of it
   // are addressable; any bits beyond that are never enabled.
   localparam int FE_W = (WIDTH > 16) ? 16 : WIDTH;

   // Counter value on the last cycle of a qualifying run of differing samples.
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

   // Register map word addresses.
   localparam logic [1:0] C_ADDR_STATE  = 2'd0;
   localparam logic [1:0] C_ADDR_MASK   = 2'd1;
   localparam logic [1:0] C_ADDR_EDGE   = 2'd2;
   localparam logic [1:0] C_ADDR_ENABLE = 2'd3;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_stable;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_edge_capture;
   logic [WIDTH-1:0] r_irq_mask;
   logic [WIDTH-1:0] r_rise_en;
   logic [FE_W-1:0]  r_fall_en;
   logic [31:0]      r_readdata;
   logic             r_irq;

   // ------------------------------------------------------------------------
   // Combinational
   // ------------------------------------------------------------------------
   logic             w_write;
   logic             w_wr_mask;
   logic             w_wr_edge;
   logic             w_wr_enable;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] w_fall_en;
   logic [WIDTH-1:0] w_event;
   logic [31:0]      w_rdata;
   logic             w_unused;

   assign w_write     = chipselect & ~write_n;
   assign w_wr_mask   = w_write && (address == C_ADDR_MASK);
   assign w_wr_edge   = w_write && (address == C_ADDR_EDGE);
   assign w_wr_enable = w_write && (address == C_ADDR_ENABLE);

   // Write-1-to-clear mask, only active on a write to the capture register.
   assign w_clr = w_wr_edge ? writedata[WIDTH-1:0] : '0;

   // Upper writedata bits are not used for every WIDTH.
   assign w_unused = ^writedata;

   // Widen the fall-enable field to WIDTH with unreachable bits held at 0.
   always_comb begin
      w_fall_en             = '0;
      w_fall_en[FE_W-1:0]   = r_fall_en;
   end

   // Qualified edge events on the debounced levels.
   assign w_event = (r_stable & ~r_prev & r_rise_en) |
                    (~r_stable & r_prev & w_fall_en);

   // ------------------------------------------------------------------------
   // Two-flop synchroniser per bit
   // ------------------------------------------------------------------------
   // Bring the asynchronous pin levels into the clk domain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= pins_in;
         r_sync2 <= r_sync1;
      end
   end

   // ------------------------------------------------------------------------
   // Per-bit debounce: the synchronised level must differ from the stable
   // level for DEBOUNCE_CYCLES consecutive clocks before it is accepted. Any
   // reversion restarts the count from zero.
   // ------------------------------------------------------------------------
   for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
      logic [CNT_W-1:0] r_cnt;
      logic             r_level;

      // Count consecutive disagreeing samples and adopt the new level at the limit.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
         end else if (r_sync2[i] == r_level) begin
            r_cnt   <= '0;
         end else if (r_cnt == C_CNT_LAST) begin
            r_level <= r_sync2[i];
            r_cnt   <= '0;
         end else begin
            r_cnt   <= r_cnt + C_CNT_ONE;
         end
      end

      assign r_stable[i] = r_level;
   end

   assign debounced = r_stable;

   // ------------------------------------------------------------------------
   // Edge detection and sticky capture
   // ------------------------------------------------------------------------
   // Delay the stable levels by one clock and accumulate events; a new event
   // on the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev         <= '0;
         r_edge_capture <= '0;
      end else begin
         r_prev         <= r_stable;
         r_edge_capture <= (r_edge_capture & ~w_clr) | w_event;
      end
   end

   // ------------------------------------------------------------------------
   // Control registers
   // ------------------------------------------------------------------------
   // Software-writable interrupt mask.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irq_mask <= '0;
      end else if (w_wr_mask) begin
         r_irq_mask <= writedata[WIDTH-1:0];
      end
   end

   // Software-writable rise/fall edge enables (rise in low half, fall in high half).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rise_en <= '0;
         r_fall_en <= '0;
      end else if (w_wr_enable) begin
         r_rise_en <= writedata[WIDTH-1:0];
         r_fall_en <= writedata[16 +: FE_W];
      end
   end

   // ------------------------------------------------------------------------
   // Read path
   // ------------------------------------------------------------------------
   // Select the addressed register; unused upper bits read as zero.
   always_comb begin
      w_rdata = '0;
      case (address)
         C_ADDR_STATE:  w_rdata = 32'(r_stable);
         C_ADDR_MASK:   w_rdata = 32'(r_irq_mask);
         C_ADDR_EDGE:   w_rdata = 32'(r_edge_capture);
         C_ADDR_ENABLE: w_rdata = 32'(r_rise_en) | (32'(r_fall_en) << 16);
         default:       w_rdata = '0;
      endcase
   end

   // Register the read mux every clock so data follows the address by one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_readdata <= '0;
      end else begin
         r_readdata <= w_rdata;
      end
   end

   assign readdata = r_readdata;

   // ------------------------------------------------------------------------
   // Interrupt
   // ------------------------------------------------------------------------
   // Level interrupt from any unmasked captured edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |(r_edge_capture & r_irq_mask);
      end
   end

   assign irq = r_irq;

endmodule
`default_nettype wire
